popcount_stream: RTL
====================

POPCOUNT_STREAM -- requirements
Module: popcount_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32: input vector width in bits (>=1).
REQ-002 SHALL have parameter CNTWIDTH, default $clog2(WIDTH+1): per-word count width.
REQ-003 SHALL have parameter ACCWIDTH, default 16: frame-total width (>= CNTWIDTH).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  upstream word valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port in_vec  input  WIDTH  word whose set bits are counted.
REQ-009 SHALL have port in_last  input  1  word closes the current frame.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_count  output  CNTWIDTH  set-bit count of the word.
REQ-013 SHALL have port out_total  output  ACCWIDTH  running frame total, this word included.
REQ-014 SHALL have port out_last  output  1  copy of in_last for the word.
REQ-015 SHALL have port out_ovf  output  1  frame total has exceeded 2^ACCWIDTH-1; sticky within the frame.

Function
REQ-016 SHALL accept a word when in_valid && in_ready, and emit a result when out_valid && out_ready.
REQ-017 SHALL be a two-stage pipeline.
- S1 registers the popcount of in_vec and in_last.
- S2 registers count, total, last and ovf.
REQ-018 SHALL present a result on out_* exactly 2 cycles after acceptance when out_ready is held high, giving a throughput of 1 word/cycle.
REQ-019 SHALL advance S2 when S1 is valid and (!out_valid || out_ready).
REQ-020 SHALL advance S1 when in_valid and (S1 empty or S1 advancing).
REQ-021 SHALL drive in_ready = !S1_valid || S2_advance, with no combinational path from in_valid to in_ready.
REQ-022 SHALL hold all out_* stable while out_valid && !out_ready, and SHALL lose and duplicate no words.
REQ-023 SHALL compute the count exactly, 0..WIDTH: all-zeros gives 0 and all-ones gives WIDTH.
REQ-024 SHALL update the accumulator only on S2 advance.
- out_total = acc + count, zero-extended to ACCWIDTH.
- acc clears to 0 after a word with last=1 advances into S2, so the next word starts a fresh frame.
REQ-025 SHALL set out_ovf when acc + count exceeds 2^ACCWIDTH-1, hold it for the remaining words of the frame, and clear it with acc on frame close.
REQ-026 SHALL treat a single word with in_last=1 as a complete frame: out_total = out_count.
REQ-027 SHALL handle simultaneous S1 and S2 advance in the same cycle with no bubble.

Reset
REQ-028 SHALL, while rst=1, clear S1/S2 valid, acc, out_count, out_total, out_last and out_ovf to 0, and drive out_valid=0.
REQ-029 SHALL drive in_ready=0 during reset and in_ready=1 in the first cycle after rst deasserts.
REQ-030 SHALL discard any partial frame or in-flight word on reset mid-operation; the first word after reset starts a new frame with acc=0.

Configuration
REQ-031 SHALL support the macro POPCOUNT_STREAM_SATURATE_EN.
- Defined: out_total and acc saturate at 2^ACCWIDTH-1 on overflow.
- Undefined: out_total and acc wrap modulo 2^ACCWIDTH.
- out_ovf behaves identically in both builds.

Verification
REQ-032 SHALL cover: WIDTH=32, words 0x0, 0xFFFFFFFF(last), out_ready=1 -> counts 0, 32; totals 0, 32; out_valid 2 cycles after each accept.
REQ-033 SHALL cover: 3-word frame 0x1, 0x3, 0x7(last) then 0xF(last) -> totals 1, 3, 6, then 4 (acc cleared).
REQ-034 SHALL cover: out_ready=0 for 5 cycles mid-stream -> in_ready=0 once S1 and S2 are full; outputs held; all words delivered in order.
REQ-035 SHALL cover: ACCWIDTH=6, WIDTH=32, frame of three 0xFFFFFFFF words:
- without macro: totals 32, 0, 32 and out_ovf 0, 1, 1;
- with macro: totals 32, 63, 63.
REQ-036 SHALL cover: rst asserted for one cycle while a frame is half complete -> out_valid=0 next cycle; next frame total starts from that frame's first word.
REQ-037 SHALL cover: random in_valid/out_ready at 50% each for 10k words -> every count and total matches the scoreboard.

Source files
------------

// File: rtl/popcount_stream_if.sv
// Handshake bundle for popcount_stream: the upstream word channel and the downstream result channel.
// The master modport is the traffic source/sink, and the slave modport is the counting block.
interface popcount_stream_if #(
    parameter int WIDTH    = 32,
    parameter int CNTWIDTH = $clog2(WIDTH + 1),
    parameter int ACCWIDTH = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_vec;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [CNTWIDTH-1:0] out_count;
    logic [ACCWIDTH-1:0] out_total;
    logic                out_last;
    logic                out_ovf;

    modport master (
        output in_valid, in_vec, in_last, out_ready,
        input  in_ready, out_valid, out_count, out_total, out_last, out_ovf
    );

    modport slave (
        input  in_valid, in_vec, in_last, out_ready,
        output in_ready, out_valid, out_count, out_total, out_last, out_ovf
    );
endinterface

// File: rtl/popcount_stream.sv
// Purpose: per-word set-bit count plus a running per-frame total with a sticky overflow flag.
// Latency: 2 cycles from accept to result, 1 word/cycle; POPCOUNT_STREAM_SATURATE_EN makes the total saturate instead of wrap.
// Backpressure: a stalled output holds S2, S1 then fills, and in_ready drops; no words are lost or duplicated.
module popcount_stream #(
    parameter int WIDTH    = 32,
    parameter int CNTWIDTH = $clog2(WIDTH + 1),
    parameter int ACCWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    popcount_stream_if.slave  bus
);
    localparam int SUMW = ACCWIDTH + 1;

    function automatic logic [CNTWIDTH-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CNTWIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNTWIDTH'(v[i]);
        end
        return c;
    endfunction

    // S1: count of the accepted word
    logic                s1_vld_q,   s1_vld_d;
    logic [CNTWIDTH-1:0] s1_cnt_q,   s1_cnt_d;
    logic                s1_last_q,  s1_last_d;

    // S2: presented result
    logic                s2_vld_q,   s2_vld_d;
    logic [CNTWIDTH-1:0] s2_cnt_q,   s2_cnt_d;
    logic [ACCWIDTH-1:0] s2_total_q, s2_total_d;
    logic                s2_last_q,  s2_last_d;
    logic                s2_ovf_q,   s2_ovf_d;

    // Frame state: total so far and whether it has already overflowed
    logic [ACCWIDTH-1:0] acc_q,      acc_d;
    logic                frm_ovf_q,  frm_ovf_d;

    logic                s2_adv;
    logic                in_ready_c;
    logic                in_acc;
    logic [SUMW-1:0]     sum;
    logic                sum_ovf;
    logic [ACCWIDTH-1:0] total_nxt;
    logic                ovf_nxt;

    // in_ready depends only on registered state, reset and out_ready, never on in_valid.
    assign s2_adv     = s1_vld_q && (!s2_vld_q || bus.out_ready);
    assign in_ready_c = !rst && (!s1_vld_q || s2_adv);
    assign in_acc     = bus.in_valid && in_ready_c;

    assign sum     = {1'b0, acc_q} + SUMW'(s1_cnt_q);
    assign sum_ovf = sum[ACCWIDTH];
    assign ovf_nxt = frm_ovf_q || sum_ovf;

`ifdef POPCOUNT_STREAM_SATURATE_EN
    assign total_nxt = sum_ovf ? {ACCWIDTH{1'b1}} : sum[ACCWIDTH-1:0];
`else
    assign total_nxt = sum[ACCWIDTH-1:0];
`endif

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_cnt_d   = s1_cnt_q;
        s1_last_d  = s1_last_q;
        s2_vld_d   = s2_vld_q;
        s2_cnt_d   = s2_cnt_q;
        s2_total_d = s2_total_q;
        s2_last_d  = s2_last_q;
        s2_ovf_d   = s2_ovf_q;
        acc_d      = acc_q;
        frm_ovf_d  = frm_ovf_q;

        if (in_acc) begin
            s1_vld_d  = 1'b1;
            s1_cnt_d  = popcnt(bus.in_vec);
            s1_last_d = bus.in_last;
        end else if (s2_adv) begin
            s1_vld_d  = 1'b0;
        end

        if (s2_adv) begin
            s2_vld_d   = 1'b1;
            s2_cnt_d   = s1_cnt_q;
            s2_total_d = total_nxt;
            s2_last_d  = s1_last_q;
            s2_ovf_d   = ovf_nxt;
            // A closing word restarts the frame for whatever follows it.
            acc_d      = s1_last_q ? '0 : total_nxt;
            frm_ovf_d  = s1_last_q ? 1'b0 : ovf_nxt;
        end else if (bus.out_ready) begin
            s2_vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_cnt_q   <= '0;
            s1_last_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_cnt_q   <= '0;
            s2_total_q <= '0;
            s2_last_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
            acc_q      <= '0;
            frm_ovf_q  <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_last_q  <= s1_last_d;
            s2_vld_q   <= s2_vld_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_total_q <= s2_total_d;
            s2_last_q  <= s2_last_d;
            s2_ovf_q   <= s2_ovf_d;
            acc_q      <= acc_d;
            frm_ovf_q  <= frm_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = s2_vld_q && !rst;
    assign bus.out_count = s2_cnt_q;
    assign bus.out_total = s2_total_q;
    assign bus.out_last  = s2_last_q;
    assign bus.out_ovf   = s2_ovf_q;
endmodule
